calc_req_arbiter: RTL

// Shares one registered add/sub arithmetic unit (the wd-wide I0/I1 -> O calc

---
 rtl/calc_req_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/calc_req_arbiter.sv
// Arbitrates NREQ requesters onto one shared registered add/sub calc unit.
// Define CALC_ARB_RR_EN for round-robin grant; default is fixed priority (lowest index).
module calc_req_arbiter #(
  parameter int NREQ     = 4,
  parameter int WD       = 16,
  parameter int CALC_LAT = 1,
  parameter int IDW      = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_op,
  input  logic [NREQ*WD-1:0]   req_i0,
  input  logic [NREQ*WD-1:0]   req_i1,
  output logic                 calc_start,
  output logic                 calc_op,
  output logic [WD-1:0]        calc_i0,
  output logic [WD-1:0]        calc_i1,
  input  logic [WD-1:0]        calc_o,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [WD-1:0]        rsp_data,
  output logic                 busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int             CW       = $clog2(CALC_LAT + 1);
  localparam logic [CW-1:0]  LAT_INIT = CW'(CALC_LAT);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q,   cnt_d;
  logic [WD-1:0]  i0_q,    i0_d;
  logic [WD-1:0]  i1_q,    i1_d;
  logic           op_q,    op_d;
  logic [IDW-1:0] id_q,    id_d;
  logic [WD-1:0]  data_q,  data_d;

  logic [NREQ-1:0] search_vec;
  logic            found;
  logic [IDW-1:0]  gnt_idx;
  logic [WD-1:0]   gnt_i0;
  logic [WD-1:0]   gnt_i1;
  logic            gnt_op;

`ifdef CALC_ARB_RR_EN
  localparam logic [IDW:0] NREQ_W = (IDW + 1)'(NREQ);

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [2*NREQ-1:0] rot_vec;
  logic [IDW:0]     idx_sum;

  // Rotate so the search always scans from bit 0; the hit is mapped back by adding the pointer.
  assign rot_vec    = {req_valid, req_valid} >> ptr_q;
  assign search_vec = rot_vec[NREQ-1:0];

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx_sum = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && search_vec[k]) begin
        found   = 1'b1;
        idx_sum = (IDW + 1)'(k) + {1'b0, ptr_q};
        if (idx_sum >= NREQ_W) begin
          idx_sum = idx_sum - NREQ_W;
        end
        gnt_idx = idx_sum[IDW-1:0];
      end
    end
  end
`else
  assign search_vec = req_valid;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && search_vec[k]) begin
        found   = 1'b1;
        gnt_idx = IDW'(k);
      end
    end
  end
`endif

  always_comb begin
    gnt_i0 = '0;
    gnt_i1 = '0;
    gnt_op = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (gnt_idx == IDW'(k)) begin
        gnt_i0 = req_i0[k*WD +: WD];
        gnt_i1 = req_i1[k*WD +: WD];
        gnt_op = req_op[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    i0_d    = i0_q;
    i1_d    = i1_q;
    op_d    = op_q;
    id_d    = id_q;
    data_d  = data_q;
`ifdef CALC_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          i0_d    = gnt_i0;
          i1_d    = gnt_i1;
          op_d    = gnt_op;
          id_d    = gnt_idx;
          state_d = S_ISSUE;
`ifdef CALC_ARB_RR_EN
          ptr_d   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
`endif
        end
      end
      S_ISSUE: begin
        cnt_d   = LAT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == CNT_ONE) begin
          data_d  = calc_o;
          cnt_d   = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      i0_q    <= '0;
      i1_q    <= '0;
      op_q    <= 1'b0;
      id_q    <= '0;
      data_q  <= '0;
`ifdef CALC_ARB_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      i0_q    <= i0_d;
      i1_q    <= i1_d;
      op_q    <= op_d;
      id_q    <= id_d;
      data_q  <= data_d;
`ifdef CALC_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign req_ready  = (state_q == S_IDLE && found) ? (NREQ'(1) << gnt_idx) : '0;
  assign calc_start = (state_q == S_ISSUE);
  assign calc_op    = op_q;
  assign calc_i0    = i0_q;
  assign calc_i1    = i1_q;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_id     = id_q;
  assign rsp_data   = data_q;
  assign busy       = (state_q != S_IDLE);

endmodule
